// File: rtl/greenhouse_display_pkg.sv
// Shared types and helpers for the value_display overlay: font cell size,
// BCD digit type, converter state encoding and the decimal overflow limit.
package greenhouse_display_pkg;

  localparam int FONT_W = 16;
  localparam int FONT_H = 32;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} vd_state_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned result;
    result = 1;
    for (int unsigned i = 0; i < n; i++) result = result * 10;
    return result;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, VALUE_W cycles in
// CONVERT, then a single DONE cycle presenting the BCD result.
module bin2bcd_seq
  import greenhouse_display_pkg::*;
#(
  parameter int VALUE_W    = 10,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  input  logic [VALUE_W-1:0]      i_bin,
  output logic                    o_ready,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);

  localparam int CNT_W = $clog2(VALUE_W + 1);

  vd_state_t               r_state;
  vd_state_t               w_stateNext;
  logic [VALUE_W-1:0]      r_bin;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [4*NUM_DIGITS-1:0] w_bcdAdj;
  logic [CNT_W-1:0]        r_count;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_stateNext = CONVERT;
      end
      CONVERT: begin
        if (r_count == CNT_W'(1)) w_stateNext = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Nibbles that would reach 10 after the coming doubling get +3 first.
  always_comb begin
    w_bcdAdj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcdAdj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin   <= '0;
      r_bcd   <= '0;
      r_count <= '0;
    end else if (r_state == IDLE && i_valid) begin
      r_bin   <= i_bin;
      r_bcd   <= '0;
      r_count <= CNT_W'(VALUE_W);
    end else if (r_state == CONVERT) begin
      {r_bcd, r_bin} <= {w_bcdAdj, r_bin} << 1;
      r_count        <= r_count - 1'b1;
    end
  end

  assign o_bcd = r_bcd;

endmodule

// File: rtl/font16x32.sv
// 16x32 decimal glyph generator drawn as seven bar segments; codes above 9
// render as an empty cell.
module font16x32
  import greenhouse_display_pkg::*;
(
  input  bcd_digit_t i_code,
  input  logic [3:0] i_col,
  input  logic [4:0] i_row,
  output logic       o_lit
);

  logic [6:0] w_seg;
  logic w_rowA, w_rowG, w_rowD, w_upper, w_lower, w_hBar, w_left, w_right;

  // Segment mask ordered {g,f,e,d,c,b,a}.
  always_comb begin
    w_seg = 7'h00;
    case (i_code)
      4'd0: w_seg = 7'h3F;
      4'd1: w_seg = 7'h06;
      4'd2: w_seg = 7'h5B;
      4'd3: w_seg = 7'h4F;
      4'd4: w_seg = 7'h66;
      4'd5: w_seg = 7'h6D;
      4'd6: w_seg = 7'h7D;
      4'd7: w_seg = 7'h07;
      4'd8: w_seg = 7'h7F;
      4'd9: w_seg = 7'h6F;
      default: w_seg = 7'h00;
    endcase
  end

  assign w_rowA  = (i_row >= 5'd1)  && (i_row <= 5'd3);
  assign w_rowG  = (i_row >= 5'd15) && (i_row <= 5'd16);
  assign w_rowD  = (i_row >= 5'd28) && (i_row <= 5'd30);
  assign w_upper = (i_row >= 5'd2)  && (i_row <= 5'd15);
  assign w_lower = (i_row >= 5'd16) && (i_row <= 5'd29);
  assign w_hBar  = (i_col >= 4'd3)  && (i_col <= 4'd12);
  assign w_left  = (i_col >= 4'd1)  && (i_col <= 4'd3);
  assign w_right = (i_col >= 4'd12) && (i_col <= 4'd14);

  assign o_lit = (w_seg[0] && w_rowA  && w_hBar)
              || (w_seg[1] && w_upper && w_right)
              || (w_seg[2] && w_lower && w_right)
              || (w_seg[3] && w_rowD  && w_hBar)
              || (w_seg[4] && w_lower && w_left)
              || (w_seg[5] && w_upper && w_left)
              || (w_seg[6] && w_rowG  && w_hBar);

endmodule

// File: rtl/value_display.sv
// N-digit decimal overlay: converted values wait as pending and are committed
// only on frame_start so a frame never tears. Option: LEADING_ZERO_BLANK_EN.
module value_display
  import greenhouse_display_pkg::*;
#(
  parameter int X1          = 0,
  parameter int Y1          = 50,
  parameter int NUM_DIGITS  = 3,
  parameter int VALUE_W     = 10,
  parameter int DIGIT_PITCH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  output logic               value_ready,
  input  logic               frame_start,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic               overflow,
  output logic               on_value_display
);

  localparam int unsigned MAX_SHOWN = pow10(NUM_DIGITS) - 1;
  localparam logic [4*NUM_DIGITS-1:0] NINES = {NUM_DIGITS{4'd9}};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [NUM_DIGITS-1:0] RESET_BLANK = ~NUM_DIGITS'(1);
`else
  localparam logic [NUM_DIGITS-1:0] RESET_BLANK = '0;
`endif

  logic                    w_done;
  logic [4*NUM_DIGITS-1:0] w_bcd;
  logic                    r_ovfNext;
  logic [4*NUM_DIGITS-1:0] r_pendDigits;
  logic                    r_pendOvf;
  logic                    r_pendValid;
  logic [4*NUM_DIGITS-1:0] r_shownDigits;
  logic [NUM_DIGITS-1:0]   r_shownBlank;
  logic [NUM_DIGITS-1:0]   w_blankNext;
  logic [NUM_DIGITS-1:0]   w_hit;
  logic                    r_overflow;
  logic                    r_on;

  bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .i_valid (value_valid),
    .i_bin   (value),
    .o_ready (value_ready),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  assign w_blankNext[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_blank
`ifdef LEADING_ZERO_BLANK_EN
    assign w_blankNext[k] = ((r_pendDigits >> (4*k)) == '0);
`else
    assign w_blankNext[k] = 1'b0;
`endif
  end

  // DONE refills pending; a frame_start in that same cycle commits only what
  // was already pending, so the fresh value waits for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovfNext     <= 1'b0;
      r_pendDigits  <= '0;
      r_pendOvf     <= 1'b0;
      r_pendValid   <= 1'b0;
      r_shownDigits <= '0;
      r_shownBlank  <= RESET_BLANK;
      r_overflow    <= 1'b0;
    end else begin
      if (value_valid && value_ready)
        r_ovfNext <= ({{(32-VALUE_W){1'b0}}, value} > MAX_SHOWN);
      if (w_done) begin
        r_pendDigits <= r_ovfNext ? NINES : w_bcd;
        r_pendOvf    <= r_ovfNext;
        r_pendValid  <= 1'b1;
      end else if (frame_start && r_pendValid) begin
        r_pendValid <= 1'b0;
      end
      if (frame_start && r_pendValid) begin
        r_shownDigits <= r_pendDigits;
        r_shownBlank  <= w_blankNext;
        r_overflow    <= r_pendOvf;
      end
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int ORIGIN_X = X1 + (NUM_DIGITS - 1 - k) * DIGIT_PITCH;
    logic       w_inBox;
    logic       w_lit;
    logic [3:0] w_col;
    logic [4:0] w_row;

    assign w_inBox = (int'(x) >= ORIGIN_X) && (int'(x) < ORIGIN_X + FONT_W)
                  && (int'(y) >= Y1) && (int'(y) < Y1 + FONT_H);
    assign w_col = 4'(x - 10'(ORIGIN_X));
    assign w_row = 5'(y - 10'(Y1));

    font16x32 u_font (
      .i_code (r_shownDigits[4*k +: 4]),
      .i_col  (w_col),
      .i_row  (w_row),
      .o_lit  (w_lit)
    );

    assign w_hit[k] = w_inBox && w_lit && !r_shownBlank[k];
  end

  always_ff @(posedge clk) begin
    if (reset) r_on <= 1'b0;
    else       r_on <= |w_hit;
  end

  assign overflow         = r_overflow;
  assign on_value_display = r_on;

endmodule
